conv_output_reader: RTL and testbench
=====================================

CONV_OUTPUT_READER -- requirements
Module: conv_output_reader

Interface
REQ-001 SHALL have parameter outRow, default 13, meaning rows of the convolution output feature map.
REQ-002 SHALL have parameter outColumn, default 12, meaning columns of the convolution output feature map.
REQ-003 SHALL have parameter addressWidth, default 16, meaning output-memory address width.
REQ-004 SHALL have parameter dataWidth, default 9, meaning signed element width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset (reset==0 resets on the clk edge).
REQ-007 SHALL have port startRead, input, 1, request to drain the whole feature map.
REQ-008 SHALL have port ram_read_enable, output, 1, read strobe to the output memory.
REQ-009 SHALL have port ram_address, output, addressWidth, read address; row-major, row*outColumn+col.
REQ-010 SHALL have port ram_data, input, dataWidth signed, memory data, valid exactly one cycle after a ram_read_enable cycle.
REQ-011 SHALL have port out_data, output, dataWidth signed, streamed element.
REQ-012 SHALL have port out_valid, output, 1, out_data holds a valid element.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts; transfer when out_valid && out_ready.
REQ-014 SHALL have port out_last, output, 1, high with the element at address outRow*outColumn-1.
REQ-015 SHALL have port busy, output, 1, high from accepted start until readDone.
REQ-016 SHALL have port readDone, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE: startRead==1 SHALL move to FETCH, clear the read address and the output counter to 0; startRead is ignored in every other state.
REQ-019 FETCH: SHALL assert ram_read_enable only when (buffered entries + reads in flight) < 2, incrementing ram_address after each issued read.
REQ-020 FETCH SHALL move to DRAIN in the cycle after the read of address outRow*outColumn-1 is issued.
REQ-021 Returned ram_data SHALL be captured unconditionally into a 2-entry FIFO; no element is ever lost or duplicated.
REQ-022 out_data/out_valid/out_last SHALL be driven from the FIFO head; a transfer pops the head.
REQ-023 While out_valid==1 and out_ready==0, out_data, out_valid and out_last SHALL hold stable.
REQ-024 With out_ready held at 1, first out_valid SHALL occur 3 cycles after the edge sampling startRead, followed by one element per cycle with no bubbles.
REQ-025 DRAIN SHALL move to DONE on the transfer with out_last==1; DONE SHALL assert readDone for exactly one cycle and return to IDLE.
REQ-026 busy SHALL deassert in the same cycle readDone is asserted.
REQ-027 Outputs SHALL be emitted in strict address order 0 .. outRow*outColumn-1.
REQ-028 outRow=outColumn=1 SHALL work: single element with out_last=1.
REQ-029 ram_read_enable SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-030 reset==0 SHALL force IDLE and set ram_read_enable=0, ram_address=0, out_valid=0, out_last=0, out_data=0, busy=0, readDone=0.
REQ-031 reset==0 mid-operation SHALL discard FIFO contents and in-flight reads; memory data arriving the next cycle is ignored.

Configuration
REQ-032 Macro READER_RELU_EN defined: out_data SHALL be 0 for negative elements, unchanged otherwise; undefined: out_data SHALL equal the stored value; timing identical in both builds.

Verification
REQ-033 outRow=13, outColumn=12, memory filled addr-mod-256 pattern, out_ready=1, startRead pulse -> 156 transfers in order, first out_valid 3 cycles after start, out_last on element 155, one readDone.
REQ-034 Same stimulus, out_ready toggling 1/0 each cycle plus a 10-cycle low stall -> 156 in-order transfers, held data stable during stalls, ram_read_enable never with 2 occupied+in-flight.
REQ-035 startRead pulsed again at element 50 -> ignored; still exactly 156 transfers and one readDone.
REQ-036 reset=0 for one cycle at element 80, then new startRead -> all outputs at reset values, fresh stream starts at address 0, 156 transfers.
REQ-037 Memory value -5 (9-bit 0x1FB) -> out_data 0 with READER_RELU_EN, 0x1FB without.
REQ-038 outRow=outColumn=1, value 7 -> single transfer, out_data=7, out_last=1, readDone next cycle.

Source files
------------

// File: rtl/conv_output_reader.sv
// Streams a row-major convolution output map from a one-cycle-latency memory
// through a 2-entry FIFO onto a valid/ready port. Define READER_RELU_EN to clamp negative elements to 0.
module conv_output_reader #(
    parameter int unsigned outRow       = 13,
    parameter int unsigned outColumn    = 12,
    parameter int unsigned addressWidth = 16,
    parameter int unsigned dataWidth    = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startRead,
    output logic                        ram_read_enable,
    output logic [addressWidth-1:0]     ram_address,
    input  logic signed [dataWidth-1:0] ram_data,
    output logic signed [dataWidth-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        readDone
);
    localparam int unsigned TOTAL = outRow * outColumn;
    localparam int unsigned AW    = addressWidth;
    localparam int unsigned DW    = dataWidth;
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q;
    logic [AW-1:0]        out_cnt_q;
    logic                 armed_q;
    logic                 pend_q;
    logic signed [DW-1:0] fifo_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 pop;
    logic                 issue;
    logic                 start_ok;
    logic                 last_pop;
    logic [2:0]           occupancy;
    logic signed [DW-1:0] head;

    // Next state and read issue; occupancy counts the pop of this cycle so the
    // FIFO plus the one read in flight never exceeds two entries.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        issue     = 1'b0;
        last_pop  = 1'b0;
        pop       = (count_q != 2'd0) && out_ready;
        occupancy = 3'(count_q) + 3'(pend_q) - 3'(pop);
        unique case (state_q)
            IDLE: begin
                if (startRead) begin
                    start_ok = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                issue = armed_q && (occupancy < 3'd2);
                if (issue && (addr_q == LAST_ADDR)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                last_pop = pop && (out_cnt_q == LAST_ADDR);
                if (last_pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The first FETCH cycle is an arming cycle, giving a three-cycle start-to-valid latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            out_cnt_q <= '0;
            armed_q   <= 1'b0;
            pend_q    <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= (state_q == FETCH);
            pend_q  <= issue;
            busy_q  <= (state_d == FETCH) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
            count_q <= occupancy[1:0];

            if (start_ok) begin
                addr_q <= '0;
            end else if (issue) begin
                addr_q <= addr_q + AW'(1);
            end

            if (start_ok) begin
                out_cnt_q <= '0;
            end else if (pop) begin
                out_cnt_q <= out_cnt_q + AW'(1);
            end

            if (pend_q) begin
                fifo_q[wr_ptr_q] <= ram_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end

            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head            = fifo_q[rd_ptr_q];
    assign ram_read_enable = issue && reset;
    assign ram_address     = addr_q;
    assign out_valid       = (count_q != 2'd0);
    assign out_last        = out_valid && (out_cnt_q == LAST_ADDR);
    assign busy            = busy_q;
    assign readDone        = done_q;

`ifdef READER_RELU_EN
    assign out_data = head[DW-1] ? '0 : head;
`else
    assign out_data = head;
`endif

endmodule

// File: tb/tb_conv_output_reader.sv
// Scoreboard bench for conv_output_reader: 13x12 map under several ready patterns,
// restart/reset disturbances, a negative element, and a 1x1 map.
`timescale 1ns/1ps
module tb_conv_output_reader;
    localparam int TOTAL = 156;
    localparam int DW    = 9;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_read;
    logic          ram_read_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          read_done;

    logic          start1;
    logic          rre1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] ram_data1;
    logic [DW-1:0] out_data1;
    logic          out_valid1;
    logic          out_ready1;
    logic          out_last1;
    logic          busy1;
    logic          read_done1;

    always #5 clk = ~clk;

    conv_output_reader #(.outRow(13), .outColumn(12), .addressWidth(AW), .dataWidth(DW)) dut (
        .clk(clk), .reset(reset), .startRead(start_read),
        .ram_read_enable(ram_read_enable), .ram_address(ram_address), .ram_data(ram_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .readDone(read_done));

    conv_output_reader #(.outRow(1), .outColumn(1), .addressWidth(AW), .dataWidth(DW)) dut1 (
        .clk(clk), .reset(reset), .startRead(start1),
        .ram_read_enable(rre1), .ram_address(addr1), .ram_data(ram_data1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_last(out_last1), .busy(busy1), .readDone(read_done1));

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic [DW-1:0] mem [TOTAL];
    exp_t          sb [$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            xfers = 0;
    int            dones = 0;
    int            last_xfer_cyc = 0;
    int            rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef READER_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: data valid for one cycle after each read cycle, garbage otherwise.
    initial begin
        logic          en_s;
        logic [AW-1:0] a_s;
        ram_data = '0;
        forever begin
            @(negedge clk);
            en_s = ram_read_enable;
            a_s  = ram_address;
            @(posedge clk);
            #1;
            if (en_s && (int'(a_s) < TOTAL)) ram_data = mem[a_s];
            else                              ram_data = DW'($urandom);
        end
    end

    initial begin
        logic en_s;
        ram_data1 = '0;
        forever begin
            @(negedge clk);
            en_s = rre1;
            @(posedge clk);
            #1;
            ram_data1 = en_s ? DW'(7) : DW'($urandom);
        end
    end

    // Ready pattern: 0 = always ready, 1 = toggling with a 10-cycle low window, 2 = held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 100) >= 60 && (cyc % 100) < 70) ? 1'b0 : 1'((cyc % 2) == 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks flow-control rules.
    initial begin
        int            outst = 0;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        logic          pop;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb.delete();
                outst      = 0;
                prev_stall = 1'b0;
            end else begin
                pop = out_valid && out_ready;
                if (ram_read_enable) check("credit_limit", 32'((outst - int'(pop)) < 2), 32'(1));
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'(1));
                    check("hold_data", 32'(out_data), 32'(prev_data));
                    check("hold_last", 32'(out_last), 32'(prev_last));
                end
                if (pop) begin
                    if (sb.size() == 0) begin
                        check("unexpected_xfer_queue_depth", 32'(sb.size()), 32'(1));
                    end else begin
                        e = sb.pop_front();
                        check("xfer_data", 32'(out_data), 32'(e.data));
                        check("xfer_last", 32'(out_last), 32'(e.last));
                    end
                    xfers++;
                    last_xfer_cyc = cyc;
                end
                if (read_done) begin
                    dones++;
                    check("busy_low_at_done", 32'(busy), 32'(0));
                end
                outst      = outst + int'(ram_read_enable) - int'(pop);
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    task automatic push_expected();
        for (int i = 0; i < TOTAL; i++) begin
            exp_t e;
            e.data = relu(mem[i]);
            e.last = (i == TOTAL - 1);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start_read = 1'b1;
        @(posedge clk);
        #2 start_read = 1'b0;
    endtask

    // Negedges from the start-sampling edge to first valid; 4 means valid after the third edge.
    task automatic measure_latency(output int t0);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("first_valid_latency", 32'(n), 32'(4));
        t0 = cyc;
    endtask

    task automatic wait_done(input int base);
        int guard = 0;
        while (dones == base && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_xfers(input int base, input int n);
        int guard = 0;
        while ((xfers - base) < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_element", 32'(xfers - base), 32'(n));
    endtask

    task automatic end_of_run(input string name, input int bx, input int bd);
        check({name, "_xfers"}, 32'(xfers - bx), 32'(TOTAL));
        check({name, "_dones"}, 32'(dones - bd), 32'(1));
        check({name, "_queue_left"}, 32'(sb.size()), 32'(0));
        check({name, "_idle_rre"}, 32'(ram_read_enable), 32'(0));
        check({name, "_idle_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int bx, bd, t0, n;
        reset      = 1'b0;
        start_read = 1'b0;
        start1     = 1'b0;
        out_ready1 = 1'b1;
        for (int i = 0; i < TOTAL; i++) mem[i] = DW'(i % 256);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rre", 32'(ram_read_enable), 32'(0));
        check("rst_addr", 32'(ram_address), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_last", 32'(out_last), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(read_done), 32'(0));
        @(posedge clk);
        #2 reset = 1'b1;

        // Full-rate drain.
        rdy_mode = 0;
        bx = xfers; bd = dones;
        push_expected();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'(1));
        measure_latency(t0);
        wait_done(bd);
        check("no_bubbles_span", 32'(last_xfer_cyc - t0), 32'(TOTAL - 1));
        end_of_run("run_full", bx, bd);

        // Toggling ready with a long stall.
        rdy_mode = 1;
        bx = xfers; bd = dones;
        push_expected();
        pulse_start();
        measure_latency(t0);
        wait_done(bd);
        end_of_run("run_toggle", bx, bd);

        // Second start while busy must be ignored.
        rdy_mode = 0;
        bx = xfers; bd = dones;
        push_expected();
        pulse_start();
        measure_latency(t0);
        wait_xfers(bx, 50);
        pulse_start();
        wait_done(bd);
        end_of_run("run_restart", bx, bd);

        // Reset mid-stream, then a fresh stream.
        bx = xfers;
        push_expected();
        pulse_start();
        measure_latency(t0);
        wait_xfers(bx, 80);
        rdy_mode = 2;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("midrst_rre", 32'(ram_read_enable), 32'(0));
        check("midrst_addr", 32'(ram_address), 32'(0));
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_last", 32'(out_last), 32'(0));
        check("midrst_data", 32'(out_data), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(read_done), 32'(0));
        rdy_mode = 0;
        bx = xfers; bd = dones;
        push_expected();
        pulse_start();
        measure_latency(t0);
        wait_done(bd);
        end_of_run("run_after_reset", bx, bd);

        // Negative element at address 3 (-5).
        mem[3] = 9'h1FB;
        bx = xfers; bd = dones;
        push_expected();
        pulse_start();
        measure_latency(t0);
        wait_done(bd);
        end_of_run("run_negative", bx, bd);
        mem[3] = DW'(3);

        // 1x1 map.
        @(posedge clk);
        #2 start1 = 1'b1;
        @(posedge clk);
        #2 start1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid1 && n < 20);
        check("single_latency", 32'(n), 32'(4));
        check("single_data", 32'(out_data1), 32'(7));
        check("single_last", 32'(out_last1), 32'(1));
        check("single_addr", 32'(addr1), 32'(1));
        @(negedge clk);
        check("single_done", 32'(read_done1), 32'(1));
        check("single_busy_at_done", 32'(busy1), 32'(0));
        check("single_valid_after", 32'(out_valid1), 32'(0));
        @(negedge clk);
        check("single_done_pulse", 32'(read_done1), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
